mips_mc_ctrl: RTL and testbench
===============================

// Module: mips_mc_ctrl
// PURPOSE
//  Multi-cycle control FSM for the MIPS core. Sequences PC, IM/IR, RF, ALU, EXT, NPC and DM
//  through FETCH/DCD/EXE/MEM/WB. Decodes Op/Funct, waits on a data-memory ready handshake,
//  flags illegal opcodes and memory timeouts, and counts retired instructions.
//  Sits beside the datapath in mips; drives every write enable and mux select.
// PARAMETERS
//  MEM_TIMEOUT  16  max MEM-state cycles awaiting MemRdy; 0 = wait forever
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      reset, asynchronous, active-low
//  Op       in   6      instr[31:26]
//  Funct    in   6      instr[5:0]
//  Zero     in   1      ALU zero flag (valid in EXE)
//  MemRdy   in   1      DM access complete this cycle
//  PCWr     out  1      PC write enable
//  IRWr     out  1      IR write enable
//  RFWr     out  1      RF write enable
//  DMWr     out  1      DM write enable
//  EXTOp    out  2      00 zero-ext, 01 sign-ext, 10 imm<<16
//  ALUOp    out  2      00 ADD, 01 SUB, 10 OR, 11 reserved
//  NPCOp    out  2      00 PC+4, 01 branch, 10 jump, 11 jr (rs)
//  BSel     out  1      ALU B: 0 RD2, 1 EXT
//  WDSel    out  2      RF WD: 00 ALU, 01 DM, 10 PC+4
//  GPRSel   out  2      RF A3: 00 rd, 01 rt, 10 r31
//  Illegal  out  1      1-cycle pulse: undecodable instruction
//  BusErr   out  1      1-cycle pulse: MEM timeout
//  InstrCnt out  CNT_W  retired instructions
// BEHAVIOUR
//  - Encoding: R 000000 (addu 100001, subu 100011, jr 001000), ori 001101, lui 001111,
//    lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
//  - Reset (rst=0): state=FETCH, InstrCnt=0, Illegal=BusErr=0, timeout ctr=0.
//    PCWr/IRWr/RFWr/DMWr forced 0 while rst=0. Selects: 0.
//  - State registered; outputs combinational from state, Op, Funct, Zero, MemRdy.
//    Unlisted outputs are 0 in every state.
//  - FETCH: IRWr=1, PCWr=1, NPCOp=00 -> DCD.
//  - DCD: j: PCWr, NPCOp=10 -> FETCH.
//    jal: same plus RFWr, GPRSel=10, WDSel=10 -> FETCH.
//    jr: PCWr, NPCOp=11 -> FETCH.
//    legal others -> EXE. Illegal: Illegal=1 next cycle, no writes, -> FETCH.
//  - EXE: addu ALUOp=00; subu ALUOp=01; both BSel=0 -> WB.
//    ori: EXTOp=00, BSel=1, ALUOp=10 -> WB. lui: EXTOp=10, BSel=1, ALUOp=00 -> WB.
//    lw/sw: EXTOp=01, BSel=1, ALUOp=00 -> MEM.
//    beq: ALUOp=01, BSel=0; Zero=1 => PCWr=1, NPCOp=01. -> FETCH either way.
//  - MEM: sw holds DMWr=1 every MEM cycle; lw holds ALU selects.
//    MemRdy=1: sw -> FETCH, lw -> WB. Timeout ctr clears on MEM entry, +1 per cycle.
//    MemRdy=0 with ctr==MEM_TIMEOUT-1 (MEM_TIMEOUT>0): BusErr=1 next cycle, -> FETCH,
//    no RF write, not counted. MemRdy wins over timeout in the same cycle.
//  - WB: RFWr=1. R-type GPRSel=00, WDSel=00; ori/lui GPRSel=01, WDSel=00;
//    lw GPRSel=01, WDSel=01 -> FETCH.
//  - InstrCnt += 1 (wraps at 2^CNT_W) on each return to FETCH of a completed instruction;
//    illegal/timeout returns excluded.
//  - Latency (cycles): j/jr/jal 2, beq 3, R/ori/lui 4, sw 4+waits, lw 5+waits.
//  - NPC sees PC already advanced in FETCH; branch/jump targets relative to PC+4.
//  - rst asserted mid-instruction: immediate return to FETCH; any pending write is dropped.
// STRUCTURE
//  - mips_ctrl_pkg: opcode/funct constants; state encoding (FETCH=0,DCD=1,EXE=2,MEM=3,WB=4);
//    EXTOp/ALUOp/NPCOp/WDSel/GPRSel encodings.
//  - Sub-module mips_ctrl_decode: combinational Op/Funct -> one-hot class
//    (rtype_add, rtype_sub, jr, ori, lui, lw, sw, beq, j, jal, illegal).
// TESTING
//  - Reset: rst=0 mid-EXE of addu -> state FETCH, all enables 0, InstrCnt=0;
//    release -> IRWr=PCWr=1 first cycle.
//  - addu (Op=0, Funct=100001) -> FETCH,DCD,EXE,WB; RFWr=1 only in WB; GPRSel=00; InstrCnt+1.
//  - beq: Zero=1 -> PCWr=1, NPCOp=01 in EXE; Zero=0 -> PCWr=0; 3 cycles each.
//  - lw, MemRdy low 3 cycles then high -> 3 extra MEM cycles, then WB with WDSel=01, GPRSel=01.
//  - sw, MemRdy never high, MEM_TIMEOUT=16 -> DMWr=1 for 16 cycles, BusErr pulse,
//    FETCH, InstrCnt unchanged.
//  - jal -> 2 cycles, RFWr=1, GPRSel=10, WDSel=10, NPCOp=10; Op=111111 -> Illegal pulse, no writes.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - shared encodings for the multi-cycle MIPS control FSM
//
// Purpose: opcode/funct constants, FSM state encoding, datapath select
// encodings and the one-hot instruction class produced by the decoder.
// Ports:   none (package).

package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4
    } state_t;

    // EXTOp
    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_HI16  = 2'b10;

    // ALUOp
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_OR    = 2'b10;

    // NPCOp
    localparam logic [1:0] NPC_PC4   = 2'b00;
    localparam logic [1:0] NPC_BR    = 2'b01;
    localparam logic [1:0] NPC_JUMP  = 2'b10;
    localparam logic [1:0] NPC_JR    = 2'b11;

    // WDSel
    localparam logic [1:0] WD_ALU    = 2'b00;
    localparam logic [1:0] WD_DM     = 2'b01;
    localparam logic [1:0] WD_PC4    = 2'b10;

    // GPRSel
    localparam logic [1:0] GPR_RD    = 2'b00;
    localparam logic [1:0] GPR_RT    = 2'b01;
    localparam logic [1:0] GPR_R31   = 2'b10;

    // Exactly one field is set for any Op/Funct pair.
    typedef struct packed {
        logic rtype_add;
        logic rtype_sub;
        logic jr;
        logic ori;
        logic lui;
        logic lw;
        logic sw;
        logic beq;
        logic j;
        logic jal;
        logic illegal;
    } instr_class_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// rtl/mips_ctrl_decode.sv - combinational Op/Funct to one-hot instruction class
//
// Purpose: classifies the instruction held in IR; anything not in the
// supported set (including unknown R-type funct codes) maps to illegal.
// Ports:
//   i_op     in  6   instr[31:26]
//   i_funct  in  6   instr[5:0]
//   o_cls    out 11  one-hot class (instr_class_t)

module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output instr_class_t o_cls
);

    always_comb begin
        o_cls = '0;
        case (i_op)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADDU: o_cls.rtype_add = 1'b1;
                    FN_SUBU: o_cls.rtype_sub = 1'b1;
                    FN_JR:   o_cls.jr        = 1'b1;
                    default: o_cls.illegal   = 1'b1;
                endcase
            end
            OP_ORI:  o_cls.ori     = 1'b1;
            OP_LUI:  o_cls.lui     = 1'b1;
            OP_LW:   o_cls.lw      = 1'b1;
            OP_SW:   o_cls.sw      = 1'b1;
            OP_BEQ:  o_cls.beq     = 1'b1;
            OP_J:    o_cls.j       = 1'b1;
            OP_JAL:  o_cls.jal     = 1'b1;
            default: o_cls.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle control FSM for the MIPS core
//
// Purpose: sequences FETCH/DCD/EXE/MEM/WB, drives every datapath write
// enable and mux select, waits on the DM ready handshake with an optional
// timeout, flags illegal instructions and counts retired instructions.
// Ports:
//   clk       in   1      clock, rising edge
//   rst       in   1      asynchronous active-low reset
//   Op/Funct  in   6/6    instruction fields from IR
//   Zero      in   1      ALU zero flag (used in EXE)
//   MemRdy    in   1      DM access complete this cycle
//   PCWr/IRWr/RFWr/DMWr   out 1   write enables (0 while rst=0)
//   EXTOp/ALUOp/NPCOp     out 2   datapath op selects
//   BSel      out  1      ALU B mux
//   WDSel/GPRSel          out 2   RF write data / address mux
//   Illegal   out  1      pulse, cycle after decoding an illegal instruction
//   BusErr    out  1      pulse, cycle after a MEM timeout
//   InstrCnt  out  CNT_W  retired-instruction counter

module mips_mc_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemRdy,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RFWr,
    output logic             DMWr,
    output logic [1:0]       EXTOp,
    output logic [1:0]       ALUOp,
    output logic [1:0]       NPCOp,
    output logic             BSel,
    output logic [1:0]       WDSel,
    output logic [1:0]       GPRSel,
    output logic             Illegal,
    output logic             BusErr,
    output logic [CNT_W-1:0] InstrCnt
);

    localparam int TMO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST =
        (MEM_TIMEOUT > 0) ? TMO_W'(MEM_TIMEOUT - 1) : '0;

    state_t             r_state;
    state_t             w_next;
    instr_class_t       w_cls;
    logic [TMO_W-1:0]   r_tmo;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_illegal;
    logic               r_buserr;

    logic               w_pcwr;
    logic               w_irwr;
    logic               w_rfwr;
    logic               w_dmwr;
    logic [1:0]         w_extop;
    logic [1:0]         w_aluop;
    logic [1:0]         w_npcop;
    logic               w_bsel;
    logic [1:0]         w_wdsel;
    logic [1:0]         w_gprsel;
    logic               w_retire;
    logic               w_illegal_evt;
    logic               w_timeout_evt;
    logic               w_tmo_hit;

    mips_ctrl_decode u_decode (
        .i_op    (Op),
        .i_funct (Funct),
        .o_cls   (w_cls)
    );

    // With MEM_TIMEOUT=0 the counter still runs but can never fire.
    assign w_tmo_hit = (MEM_TIMEOUT > 0) && (r_tmo == TMO_LAST);

    always_comb begin
        w_next        = r_state;
        w_pcwr        = 1'b0;
        w_irwr        = 1'b0;
        w_rfwr        = 1'b0;
        w_dmwr        = 1'b0;
        w_extop       = EXT_ZERO;
        w_aluop       = ALU_ADD;
        w_npcop       = NPC_PC4;
        w_bsel        = 1'b0;
        w_wdsel       = WD_ALU;
        w_gprsel      = GPR_RD;
        w_retire      = 1'b0;
        w_illegal_evt = 1'b0;
        w_timeout_evt = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_irwr  = 1'b1;
                w_pcwr  = 1'b1;
                w_npcop = NPC_PC4;
                w_next  = S_DCD;
            end

            S_DCD: begin
                if (w_cls.j || w_cls.jal) begin
                    w_pcwr   = 1'b1;
                    w_npcop  = NPC_JUMP;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                    if (w_cls.jal) begin
                        // Link address is PC+4, already in the PC after FETCH.
                        w_rfwr   = 1'b1;
                        w_gprsel = GPR_R31;
                        w_wdsel  = WD_PC4;
                    end
                end else if (w_cls.jr) begin
                    w_pcwr   = 1'b1;
                    w_npcop  = NPC_JR;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_cls.illegal) begin
                    w_illegal_evt = 1'b1;
                    w_next        = S_FETCH;
                end else begin
                    w_next = S_EXE;
                end
            end

            S_EXE: begin
                if (w_cls.rtype_add || w_cls.rtype_sub) begin
                    w_aluop = w_cls.rtype_sub ? ALU_SUB : ALU_ADD;
                    w_bsel  = 1'b0;
                    w_next  = S_WB;
                end else if (w_cls.ori) begin
                    w_extop = EXT_ZERO;
                    w_bsel  = 1'b1;
                    w_aluop = ALU_OR;
                    w_next  = S_WB;
                end else if (w_cls.lui) begin
                    w_extop = EXT_HI16;
                    w_bsel  = 1'b1;
                    w_aluop = ALU_ADD;
                    w_next  = S_WB;
                end else if (w_cls.lw || w_cls.sw) begin
                    w_extop = EXT_SIGN;
                    w_bsel  = 1'b1;
                    w_aluop = ALU_ADD;
                    w_next  = S_MEM;
                end else if (w_cls.beq) begin
                    w_aluop  = ALU_SUB;
                    w_bsel   = 1'b0;
                    w_pcwr   = Zero;
                    w_npcop  = Zero ? NPC_BR : NPC_PC4;
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end else begin
                    // Only reachable if IR changed under us; abandon quietly.
                    w_next = S_FETCH;
                end
            end

            S_MEM: begin
                if (w_cls.sw) begin
                    w_dmwr = 1'b1;
                end
                if (w_cls.lw) begin
                    // Keep the address path stable for the whole read.
                    w_extop = EXT_SIGN;
                    w_bsel  = 1'b1;
                    w_aluop = ALU_ADD;
                end
                if (!(w_cls.lw || w_cls.sw)) begin
                    w_next = S_FETCH;
                end else if (MemRdy) begin
                    // Ready is honoured even on the last allowed cycle.
                    if (w_cls.lw) begin
                        w_next = S_WB;
                    end else begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_timeout_evt = 1'b1;
                    w_next        = S_FETCH;
                end
            end

            S_WB: begin
                w_rfwr   = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                if (w_cls.lw) begin
                    w_gprsel = GPR_RT;
                    w_wdsel  = WD_DM;
                end else if (w_cls.ori || w_cls.lui) begin
                    w_gprsel = GPR_RT;
                    w_wdsel  = WD_ALU;
                end else begin
                    w_gprsel = GPR_RD;
                    w_wdsel  = WD_ALU;
                end
            end

            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_buserr  <= 1'b0;
            r_tmo     <= '0;
        end else begin
            r_state   <= w_next;
            r_illegal <= w_illegal_evt;
            r_buserr  <= w_timeout_evt;
            if (w_retire) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Zero outside MEM, so the first MEM cycle always sees 0.
            if (r_state == S_MEM) begin
                r_tmo <= r_tmo + 1'b1;
            end else begin
                r_tmo <= '0;
            end
        end
    end

    // Reset holds FETCH, whose enables are active; mask everything while rst=0.
    assign PCWr     = rst & w_pcwr;
    assign IRWr     = rst & w_irwr;
    assign RFWr     = rst & w_rfwr;
    assign DMWr     = rst & w_dmwr;
    assign EXTOp    = rst ? w_extop  : 2'b00;
    assign ALUOp    = rst ? w_aluop  : 2'b00;
    assign NPCOp    = rst ? w_npcop  : 2'b00;
    assign BSel     = rst & w_bsel;
    assign WDSel    = rst ? w_wdsel  : 2'b00;
    assign GPRSel   = rst ? w_gprsel : 2'b00;
    assign Illegal  = r_illegal;
    assign BusErr   = r_buserr;
    assign InstrCnt = r_cnt;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb/tb_mips_mc_ctrl.sv - self-checking bench for mips_mc_ctrl

module tb_mips_mc_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  Op;
    logic [5:0]  Funct;
    logic        Zero;
    logic        MemRdy;
    logic        PCWr, IRWr, RFWr, DMWr, BSel, Illegal, BusErr;
    logic [1:0]  EXTOp, ALUOp, NPCOp, WDSel, GPRSel;
    logic [31:0] InstrCnt;
    logic [14:0] obs_vec;

    always #5 clk = ~clk;

    mips_mc_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero), .MemRdy(MemRdy),
        .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr),
        .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .BSel(BSel),
        .WDSel(WDSel), .GPRSel(GPRSel), .Illegal(Illegal), .BusErr(BusErr),
        .InstrCnt(InstrCnt)
    );

    assign obs_vec = {PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, NPCOp, BSel, WDSel, GPRSel};

    typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_ILL} kind_t;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_cnt = 32'd0;
    logic        pend_ill = 1'b0;
    logic        pend_berr = 1'b0;

    function automatic logic [14:0] mk(input logic pc, ir, rf, dm, input logic [1:0] ext, alu, npc,
                                       input logic bs, input logic [1:0] wd, gpr);
        return {pc, ir, rf, dm, ext, alu, npc, bs, wd, gpr};
    endfunction

    function automatic kind_t classify(input logic [5:0] op, fn);
        kind_t k;
        case (op)
            6'b000000: begin
                case (fn)
                    6'b100001: k = K_ADDU;
                    6'b100011: k = K_SUBU;
                    6'b001000: k = K_JR;
                    default:   k = K_ILL;
                endcase
            end
            6'b001101: k = K_ORI;
            6'b001111: k = K_LUI;
            6'b100011: k = K_LW;
            6'b101011: k = K_SW;
            6'b000100: k = K_BEQ;
            6'b000010: k = K_J;
            6'b000011: k = K_JAL;
            default:   k = K_ILL;
        endcase
        return k;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [14:0] ev);
        chk({tag, ".vec"}, 32'(obs_vec), 32'(ev));
        chk({tag, ".illegal"}, 32'(Illegal), 32'(pend_ill));
        chk({tag, ".buserr"}, 32'(BusErr), 32'(pend_berr));
        chk({tag, ".cnt"}, InstrCnt, exp_cnt);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs 1ns later.
    task automatic cyc(input string tag, input logic [14:0] ev, input logic [5:0] op, fn,
                       input logic z, mr);
        @(negedge clk);
        Op = op; Funct = fn; Zero = z; MemRdy = mr;
        #1;
        check_all(tag, ev);
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
    endtask

    // Asserted at a negedge (mid-cycle), released during the following high phase.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0;
        exp_cnt   = 32'd0;
        pend_ill  = 1'b0;
        pend_berr = 1'b0;
        #1;
        check_all({tag, ".hold0"}, 15'd0);
        @(posedge clk);
        #1;
        check_all({tag, ".hold1"}, 15'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
    endtask

    // Runs one instruction; nwait = MemRdy-low cycles before ready (>= TMO times out).
    task automatic run_instr(input logic [5:0] op, fn, input logic zb, input int nwait);
        kind_t       k;
        int          nm;
        logic [14:0] mem_v;
        k = classify(op, fn);
        // IR still holds the old instruction during FETCH: drive junk.
        cyc("fetch", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 6'($urandom), 6'($urandom), rb(), rb());
        case (k)
            K_J:   begin cyc("j.dcd",   mk(1, 0, 0, 0, 0, 0, 2, 0, 0, 0), op, fn, rb(), rb()); exp_cnt++; end
            K_JAL: begin cyc("jal.dcd", mk(1, 0, 1, 0, 0, 0, 2, 0, 2, 2), op, fn, rb(), rb()); exp_cnt++; end
            K_JR:  begin cyc("jr.dcd",  mk(1, 0, 0, 0, 0, 0, 3, 0, 0, 0), op, fn, rb(), rb()); exp_cnt++; end
            K_ILL: begin cyc("ill.dcd", 15'd0, op, fn, rb(), rb()); pend_ill = 1'b1; end
            default: begin
                cyc("dcd", 15'd0, op, fn, rb(), rb());
                case (k)
                    K_ADDU: begin
                        cyc("addu.exe", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), op, fn, rb(), rb());
                        cyc("addu.wb",  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), op, fn, rb(), rb());
                        exp_cnt++;
                    end
                    K_SUBU: begin
                        cyc("subu.exe", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), op, fn, rb(), rb());
                        cyc("subu.wb",  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0), op, fn, rb(), rb());
                        exp_cnt++;
                    end
                    K_ORI: begin
                        cyc("ori.exe", mk(0, 0, 0, 0, 0, 2, 0, 1, 0, 0), op, fn, rb(), rb());
                        cyc("ori.wb",  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1), op, fn, rb(), rb());
                        exp_cnt++;
                    end
                    K_LUI: begin
                        cyc("lui.exe", mk(0, 0, 0, 0, 2, 0, 0, 1, 0, 0), op, fn, rb(), rb());
                        cyc("lui.wb",  mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1), op, fn, rb(), rb());
                        exp_cnt++;
                    end
                    K_BEQ: begin
                        cyc("beq.exe", mk(zb, 0, 0, 0, 0, 1, zb ? 2'd1 : 2'd0, 0, 0, 0), op, fn, zb, rb());
                        exp_cnt++;
                    end
                    default: begin
                        cyc("mem.exe", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), op, fn, rb(), rb());
                        mem_v = (k == K_LW) ? mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0)
                                            : mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
                        nm = (nwait >= TMO) ? TMO : nwait + 1;
                        for (int c = 0; c < nm; c++) begin
                            cyc("mem.wait", mem_v, op, fn, rb(), (nwait < TMO) && (c == nwait));
                        end
                        if (nwait >= TMO) begin
                            pend_berr = 1'b1;
                        end else begin
                            if (k == K_LW) begin
                                cyc("lw.wb", mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 1), op, fn, rb(), rb());
                            end
                            exp_cnt++;
                        end
                    end
                endcase
            end
        endcase
    endtask

    initial begin
        logic [5:0] rop;
        logic [5:0] rfn;
        int         sel;
        rst = 1'b0; Op = 6'd0; Funct = 6'd0; Zero = 1'b0; MemRdy = 1'b0;

        do_reset("por");
        run_instr(6'b000000, 6'b100001, 1'b0, 0);       // addu
        run_instr(6'b000100, 6'd0, 1'b1, 0);            // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 0);            // beq not taken
        run_instr(6'b100011, 6'd0, 1'b0, 3);            // lw, 3 waits
        run_instr(6'b101011, 6'd0, 1'b0, 100);          // sw, timeout
        run_instr(6'b000011, 6'd0, 1'b0, 0);            // jal
        run_instr(6'b111111, 6'd0, 1'b0, 0);            // illegal op
        run_instr(6'b000000, 6'b100011, 1'b0, 0);       // subu
        run_instr(6'b001101, 6'd0, 1'b0, 0);            // ori
        run_instr(6'b001111, 6'd0, 1'b0, 0);            // lui
        run_instr(6'b000010, 6'd0, 1'b0, 0);            // j
        run_instr(6'b000000, 6'b001000, 1'b0, 0);       // jr
        run_instr(6'b000000, 6'b111111, 1'b0, 0);       // illegal funct
        run_instr(6'b101011, 6'd0, 1'b0, TMO - 1);      // sw, ready on last cycle
        run_instr(6'b100011, 6'd0, 1'b0, TMO - 1);      // lw, ready on last cycle
        run_instr(6'b100011, 6'd0, 1'b0, TMO);          // lw, timeout
        run_instr(6'b101011, 6'd0, 1'b0, 0);            // sw, no wait

        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(0, 11));
            rfn = 6'($urandom);
            case (sel)
                0:  begin rop = 6'b000000; rfn = 6'b100001; end
                1:  begin rop = 6'b000000; rfn = 6'b100011; end
                2:  begin rop = 6'b000000; rfn = 6'b001000; end
                3:  rop = 6'b001101;
                4:  rop = 6'b001111;
                5:  rop = 6'b100011;
                6:  rop = 6'b101011;
                7:  rop = 6'b000100;
                8:  rop = 6'b000010;
                9:  rop = 6'b000011;
                10: rop = 6'b000000;
                default: rop = 6'($urandom);
            endcase
            run_instr(rop, rfn, rb(), int'($urandom_range(0, TMO + 2)));
        end

        // Reset during EXE of addu.
        cyc("rx.fetch", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 6'd0, 6'd0, 1'b0, 1'b0);
        cyc("rx.dcd", 15'd0, 6'b000000, 6'b100001, 1'b0, 1'b0);
        do_reset("rst_exe");
        run_instr(6'b000000, 6'b100001, 1'b0, 0);

        // Reset while sw is writing; DMWr must drop immediately.
        cyc("rm.fetch", mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0), 6'd0, 6'd0, 1'b0, 1'b0);
        cyc("rm.dcd", 15'd0, 6'b101011, 6'd0, 1'b0, 1'b0);
        cyc("rm.exe", mk(0, 0, 0, 0, 1, 0, 0, 1, 0, 0), 6'b101011, 6'd0, 1'b0, 1'b0);
        cyc("rm.mem", mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0), 6'b101011, 6'd0, 1'b0, 1'b0);
        do_reset("rst_mem");
        run_instr(6'b001101, 6'd0, 1'b0, 0);
        run_instr(6'b000000, 6'b100001, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
